// File: rtl/control_unit_packing_mc.sv
// control_unit_packing_mc
//   Queues one packet request per end_sig pulse and drains PACK_WORDS result
//   words per request from the result FIFO towards the output link. Pops are
//   gated by FIFO occupancy and downstream ready. The link beat flags are
//   registered so that they line up with the FIFO read data one cycle later.
//
//   Optional feature macro: PACK_HEADER_EN
//     defined   : a header beat (out_hdr=1, out_sop=1) precedes every packet.
//     undefined : no header state, out_hdr is tied low, out_sop on word 0.
module control_unit_packing_mc #(
  parameter int PACK_WORDS = 16,
  parameter int PEND_DEPTH = 4,
  parameter int SEQ_W      = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          end_sig,
  input  logic                          fifo_empty,
  input  logic                          out_ready,
  output logic                          pop_fout,
  output logic                          out_valid,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic                          out_hdr,
  output logic [SEQ_W-1:0]              hdr_seq,
  output logic [$clog2(PACK_WORDS)-1:0] word_idx,
  output logic                          busy,
  output logic                          req_overflow
);

  localparam int CW = $clog2(PACK_WORDS);
  localparam int PW = $clog2(PEND_DEPTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(PACK_WORDS - 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_DEPTH);

`ifdef PACK_HEADER_EN
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_POP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_POP} state_t;
`endif

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_pendCnt;
  logic             r_reqOverflow;
  logic [SEQ_W-1:0] r_hdrSeq;
  logic             r_outValid;
  logic             r_outSop;
  logic             r_outEop;
  logic [CW-1:0]    r_wordIdx;

  logic w_pop;
  logic w_lastPop;
  logic w_pendNz;
  logic w_more;
  logic w_start;
  logic w_chain;
  logic w_dec;
  logic w_hdrIssue;

  // A word leaves the FIFO only while draining, with data available and room downstream.
  assign w_pop     = (r_state == S_POP) & ~fifo_empty & out_ready;
  assign w_lastPop = w_pop & (r_cnt == LAST_IDX);
  assign w_pendNz  = (r_pendCnt != '0);
  // A request arriving on the final pop counts as pending, so packets chain without a gap.
  assign w_more    = w_pendNz | end_sig;
  assign w_start   = (r_state == S_IDLE) & w_pendNz;
  assign w_chain   = w_lastPop & w_more;
  assign w_dec     = w_start | w_chain;

`ifdef PACK_HEADER_EN
  logic r_outHdr;
  assign w_hdrIssue = (r_state == S_HEADER) & out_ready;
  assign out_hdr    = r_outHdr;
`else
  assign w_hdrIssue = 1'b0;
  assign out_hdr    = 1'b0;
`endif

  assign pop_fout     = w_pop;
  assign out_valid    = r_outValid;
  assign out_sop      = r_outSop;
  assign out_eop      = r_outEop;
  assign hdr_seq      = r_hdrSeq;
  assign word_idx     = r_wordIdx;
  assign busy         = (r_state != S_IDLE) | w_pendNz;
  assign req_overflow = r_reqOverflow;

  // Pending request counter: end_sig adds, starting a packet consumes; full drops and flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pendCnt     <= '0;
      r_reqOverflow <= 1'b0;
    end else begin
      if (end_sig && !w_dec) begin
        if (r_pendCnt == PEND_FULL) begin
          r_reqOverflow <= 1'b1;
        end else begin
          r_pendCnt <= r_pendCnt + 1'b1;
        end
      end else if (!end_sig && w_dec) begin
        r_pendCnt <= r_pendCnt - 1'b1;
      end
    end
  end

  // Packet FSM plus the registered link flags, delayed one cycle to match FIFO read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hdrSeq   <= '0;
      r_outValid <= 1'b0;
      r_outSop   <= 1'b0;
      r_outEop   <= 1'b0;
      r_wordIdx  <= '0;
`ifdef PACK_HEADER_EN
      r_outHdr   <= 1'b0;
`endif
    end else begin
      r_outValid <= w_pop | w_hdrIssue;
      r_outEop   <= w_lastPop;
      r_wordIdx  <= r_cnt;
`ifdef PACK_HEADER_EN
      r_outSop   <= w_hdrIssue;
      r_outHdr   <= w_hdrIssue;
`else
      r_outSop   <= w_pop & (r_cnt == '0);
`endif
      case (r_state)
        S_IDLE: begin
          if (w_pendNz) begin
            r_cnt <= '0;
`ifdef PACK_HEADER_EN
            r_state <= S_HEADER;
`else
            r_state <= S_POP;
`endif
          end
        end
`ifdef PACK_HEADER_EN
        S_HEADER: begin
          if (out_ready) begin
            r_state <= S_POP;
          end
        end
`endif
        S_POP: begin
          if (w_pop) begin
            if (r_cnt == LAST_IDX) begin
              r_cnt    <= '0;
              r_hdrSeq <= r_hdrSeq + 1'b1;
              if (w_more) begin
`ifdef PACK_HEADER_EN
                r_state <= S_HEADER;
`else
                r_state <= S_POP;
`endif
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_packing_mc.sv
// tb_control_unit_packing_mc
//   Expected link beats are queued whenever a packet request is issued and
//   compared beat by beat as the controller emits them. Scenario tasks add
//   their own checks on pop counts, gaps, stalls, overflow and reset.
//   Follows PACK_HEADER_EN the same way the design does.
module tb_control_unit_packing_mc;

  localparam int PW    = 16;
  localparam int PD    = 4;
  localparam int SW    = 8;
  localparam int CW    = $clog2(PW);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          end_sig = 1'b0;
  logic          fifo_empty = 1'b0;
  logic          out_ready = 1'b1;
  logic          pop_fout;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic          out_hdr;
  logic [SW-1:0] hdr_seq;
  logic [CW-1:0] word_idx;
  logic          busy;
  logic          req_overflow;

  typedef struct packed {
    logic          hdr;
    logic          sop;
    logic          eop;
    logic [CW-1:0] idx;
    logic [SW-1:0] seq;
  } beat_t;

  beat_t         expQ[$];
  beat_t         monBeat;
  logic [SW-1:0] monNext;
  logic [SW-1:0] seqModel = '0;
  int            checks = 0;
  int            errors = 0;

  control_unit_packing_mc #(
    .PACK_WORDS (PW),
    .PEND_DEPTH (PD),
    .SEQ_W      (SW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .end_sig      (end_sig),
    .fifo_empty   (fifo_empty),
    .out_ready    (out_ready),
    .pop_fout     (pop_fout),
    .out_valid    (out_valid),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_hdr      (out_hdr),
    .hdr_seq      (hdr_seq),
    .word_idx     (word_idx),
    .busy         (busy),
    .req_overflow (req_overflow)
  );

  always #5 clock = ~clock;

  // Queue the beats one accepted request must produce, tagged with its sequence number.
  task automatic pushPacket();
    beat_t b;
`ifdef PACK_HEADER_EN
    b.hdr = 1'b1; b.sop = 1'b1; b.eop = 1'b0; b.idx = '0; b.seq = seqModel;
    expQ.push_back(b);
`endif
    for (int i = 0; i < PW; i++) begin
      b.hdr = 1'b0;
`ifdef PACK_HEADER_EN
      b.sop = 1'b0;
`else
      b.sop = (i == 0);
`endif
      b.eop = (i == PW - 1);
      b.idx = CW'(i);
      b.seq = seqModel;
      expQ.push_back(b);
    end
    seqModel = seqModel + 1'b1;
  endtask

  task automatic pulseEnd();
    @(posedge clock); #1;
    end_sig = 1'b1;
    @(posedge clock); #1;
    end_sig = 1'b0;
  endtask

  // Run until the link is idle and every queued beat was seen, collecting statistics.
  task automatic drain(input int maxCyc, output int pops, output int gaps,
                       output int beats, output int runs, output int eopBusy);
    logic prevPop;
    bit   done;
    pops = 0; gaps = 0; beats = 0; runs = 0; eopBusy = 0; prevPop = 1'b0; done = 0;
    for (int c = 0; c < maxCyc; c++) begin
      @(negedge clock);
      if (pop_fout) pops++;
      if (pop_fout && !prevPop) runs++;
      if (busy && !pop_fout) gaps++;
      if (out_valid) beats++;
      if (out_valid && out_eop && busy) eopBusy++;
      prevPop = pop_fout;
      if (!busy && !out_valid && expQ.size() == 0) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain_timeout: busy=%0b queued=%0d after %0d cycles", busy, expQ.size(), maxCyc);
    end
  endtask

  // Compare every emitted beat against the front of the expected queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (pop_fout) begin
        checks++;
        if (!out_ready || fifo_empty) begin
          errors++;
          $display("[TB] FAIL illegal_pop: out_ready=%0b fifo_empty=%0b", out_ready, fifo_empty);
        end
      end
      if (out_valid) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_beat: idx=%0d sop=%0b eop=%0b hdr=%0b", word_idx, out_sop, out_eop, out_hdr);
        end else begin
          monBeat = expQ.pop_front();
          monNext = monBeat.seq + 1'b1;
          if (out_hdr !== monBeat.hdr || out_sop !== monBeat.sop || out_eop !== monBeat.eop) begin
            errors++;
            $display("[TB] FAIL beat_flags: got hdr/sop/eop=%0b%0b%0b expected %0b%0b%0b (idx %0d)",
                     out_hdr, out_sop, out_eop, monBeat.hdr, monBeat.sop, monBeat.eop, monBeat.idx);
          end
          if (!monBeat.hdr && word_idx !== monBeat.idx) begin
            errors++;
            $display("[TB] FAIL word_idx: got %0d expected %0d", word_idx, monBeat.idx);
          end
          if (monBeat.hdr && hdr_seq !== monBeat.seq) begin
            errors++;
            $display("[TB] FAIL hdr_seq_header: got %0d expected %0d", hdr_seq, monBeat.seq);
          end
          if (monBeat.eop && hdr_seq !== monNext) begin
            errors++;
            $display("[TB] FAIL hdr_seq_eop: got %0d expected %0d", hdr_seq, monNext);
          end
        end
      end
    end
  end

  task automatic test_reset();
    fifo_empty = 1'b0; out_ready = 1'b1; end_sig = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks += 4;
    if (pop_fout !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_pop_valid: got pop=%0b valid=%0b expected 0 0", pop_fout, out_valid);
    end
    if (out_sop !== 1'b0 || out_eop !== 1'b0 || out_hdr !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got sop/eop/hdr=%0b%0b%0b expected 000", out_sop, out_eop, out_hdr);
    end
    if (hdr_seq !== '0 || word_idx !== '0) begin
      errors++; $display("[TB] FAIL reset_seq_idx: got seq=%0d idx=%0d expected 0 0", hdr_seq, word_idx);
    end
    if (busy !== 1'b0 || req_overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy_ovf: got busy=%0b ovf=%0b expected 0 0", busy, req_overflow);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    expQ.delete();
    seqModel = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || pop_fout !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset_idle: got busy=%0b pop=%0b valid=%0b expected 0 0 0", busy, pop_fout, out_valid);
    end
  endtask

  task automatic test_single_packet();
    int pops, gaps, beats, runs, eopBusy;
    fifo_empty = 1'b0; out_ready = 1'b1;
    pushPacket();
    pulseEnd();
    drain(100, pops, gaps, beats, runs, eopBusy);
    checks += 4;
    if (pops != PW) begin
      errors++; $display("[TB] FAIL single_pops: got %0d expected %0d", pops, PW);
    end
    if (runs != 1) begin
      errors++; $display("[TB] FAIL single_contiguous: got %0d pop runs expected 1", runs);
    end
`ifdef PACK_HEADER_EN
    if (beats != PW + 1) begin
      errors++; $display("[TB] FAIL single_beats: got %0d expected %0d", beats, PW + 1);
    end
`else
    if (beats != PW) begin
      errors++; $display("[TB] FAIL single_beats: got %0d expected %0d", beats, PW);
    end
`endif
    if (eopBusy != 0 || hdr_seq !== seqModel) begin
      errors++; $display("[TB] FAIL single_end: busy_at_eop=%0d seq=%0d expected 0 and %0d", eopBusy, hdr_seq, seqModel);
    end
  endtask

  task automatic test_backpressure();
    int pops, firstC, lastC;
    bit done;
    fifo_empty = 1'b0; out_ready = 1'b1;
    pushPacket();
    pulseEnd();
    pops = 0; firstC = -1; lastC = -1; done = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (pop_fout) begin
        pops++;
        if (firstC < 0) firstC = c;
        lastC = c;
      end
      if (pops == PW && !busy && !out_valid) begin
        done = 1;
        break;
      end
      @(posedge clock); #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    checks += 2;
    if (!done || pops != PW) begin
      errors++; $display("[TB] FAIL stall_pops: got %0d pops done=%0b expected %0d", pops, done, PW);
    end
    if (lastC - firstC + 1 != 2 * PW - 1) begin
      errors++; $display("[TB] FAIL stall_span: got %0d cycles expected %0d", lastC - firstC + 1, 2 * PW - 1);
    end
  endtask

  // Five requests are raised while a packet is already draining: four fill the
  // queue and the fifth is dropped, so four more packets follow the running one.
  task automatic test_overflow();
    int pops, gaps, c;
    bit seen, done;
    fifo_empty = 1'b0; out_ready = 1'b1;
    pushPacket();
    pulseEnd();
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (pop_fout) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL overflow_start: got no pop expected one within 20 cycles");
    end
    for (int p = 0; p < PD; p++) pushPacket();
    pops = 0; gaps = 0; c = 0; done = 0;
    while (c < 400) begin
      end_sig = (c < 5);
      if (pop_fout) pops++;
      if (busy && !pop_fout) gaps++;
      if (c >= 5 && !busy && !out_valid && expQ.size() == 0) begin
        done = 1;
        break;
      end
      @(negedge clock);
      c++;
    end
    end_sig = 1'b0;
    checks += 4;
    if (req_overflow !== 1'b1) begin
      errors++; $display("[TB] FAIL overflow_flag: got %0b expected 1", req_overflow);
    end
    if (!done || pops != PW * (PD + 1)) begin
      errors++; $display("[TB] FAIL overflow_pops: got %0d done=%0b expected %0d", pops, done, PW * (PD + 1));
    end
`ifdef PACK_HEADER_EN
    if (gaps != PD) begin
      errors++; $display("[TB] FAIL overflow_gaps: got %0d expected %0d", gaps, PD);
    end
`else
    if (gaps != 0) begin
      errors++; $display("[TB] FAIL overflow_gaps: got %0d expected 0", gaps);
    end
`endif
    if (hdr_seq !== seqModel) begin
      errors++; $display("[TB] FAIL overflow_seq: got %0d expected %0d", hdr_seq, seqModel);
    end
  endtask

  task automatic test_back_to_back();
    int pops, gaps, beats, runs, eopBusy;
    bit fired;
    logic expPop;
    fifo_empty = 1'b0; out_ready = 1'b1;
    pushPacket();
    pulseEnd();
    pops = 0; fired = 0;
`ifdef PACK_HEADER_EN
    expPop = 1'b0;
`else
    expPop = 1'b1;
`endif
    for (int c = 0; c < 100 && !fired; c++) begin
      @(negedge clock);
      if (pop_fout) begin
        pops++;
        if (pops == PW) begin
          fired = 1;
          end_sig = 1'b1;
          pushPacket();
          @(posedge clock); #1;
          end_sig = 1'b0;
          @(negedge clock);
          checks++;
          if (pop_fout !== expPop) begin
            errors++; $display("[TB] FAIL b2b_next_start: got pop=%0b expected %0b", pop_fout, expPop);
          end
          if (pop_fout) pops++;
        end
      end
    end
    drain(100, gaps, runs, beats, eopBusy, runs);
    pops += gaps;
    checks += 2;
    if (!fired) begin
      errors++; $display("[TB] FAIL b2b_fire: got no final pop expected one");
    end
    if (pops != 2 * PW) begin
      errors++; $display("[TB] FAIL b2b_pops: got %0d expected %0d", pops, 2 * PW);
    end
  endtask

  task automatic test_reset_midpacket();
    int pops, gaps, beats, runs, eopBusy;
    bit hit;
    fifo_empty = 1'b0; out_ready = 1'b1;
    pushPacket();
    pulseEnd();
    hit = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      end_sig = (out_valid && word_idx == CW'(3));
      if (out_valid && word_idx == CW'(7)) begin
        hit = 1;
        break;
      end
    end
    end_sig = 1'b0;
    reset = 1'b1;
    expQ.delete();
    seqModel = '0;
    #1;
    checks += 3;
    if (!hit) begin
      errors++; $display("[TB] FAIL midreset_reach: got no idx 7 expected one");
    end
    if (pop_fout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_drop: got pop=%0b busy=%0b expected 0 0", pop_fout, busy);
    end
    if (out_valid !== 1'b0 || hdr_seq !== '0 || req_overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_clear: got valid=%0b seq=%0d ovf=%0b expected 0 0 0", out_valid, hdr_seq, req_overflow);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_flush: got busy=%0b expected 0", busy);
    end
    pushPacket();
    pulseEnd();
    drain(100, pops, gaps, beats, runs, eopBusy);
    checks++;
    if (pops != PW || runs != 1) begin
      errors++; $display("[TB] FAIL midreset_repack: got %0d pops in %0d runs expected %0d in 1", pops, runs, PW);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_packet();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_midpacket();
    checks++;
    if (expQ.size() != 0) begin
      errors++; $display("[TB] FAIL leftover_beats: got %0d queued expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
